// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port cpumemory: CPU priority, bounded debug wait,
// loader lock. Define MEM_ARBITER_WRPROT_EN to block CPU writes at or above PROT_BASE.
module mem_arbiter #(
  parameter int unsigned   AW        = 16,
  parameter int unsigned   DW        = 8,
  parameter int unsigned   MAX_WAIT  = 4,
  parameter logic [AW-1:0] PROT_BASE = AW'(16'hF000)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_wr_err,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          locked,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned WaitW = 4;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  typedef enum logic {StRun, StLocked} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             cpu_rvalid_q, cpu_rvalid_d;
  logic             dbg_rvalid_q, dbg_rvalid_d;
  logic             wr_err_q, wr_err_d;
  logic             cpu_gnt_raw, dbg_gnt_raw;
  logic             starve;
  logic             prot;

  always_comb begin
    starve      = 1'b0;
    cpu_gnt_raw = 1'b0;
    dbg_gnt_raw = 1'b0;
    if (state_q == StLocked) begin
      dbg_gnt_raw = dbg_req;
    end else begin
      starve      = dbg_req && (wait_q == WaitMax);
      cpu_gnt_raw = cpu_req & ~starve;
      dbg_gnt_raw = dbg_req & (~cpu_req | starve);
    end
  end

`ifdef MEM_ARBITER_WRPROT_EN
  assign prot = cpu_gnt_raw & cpu_we & (cpu_addr >= PROT_BASE);
`else
  logic unused_prot_base;
  assign unused_prot_base = ^PROT_BASE;
  assign prot = 1'b0;
`endif

  always_comb begin
    state_d = dbg_lock ? StLocked : StRun;
    wait_d  = wait_q;
    if (state_q == StLocked || dbg_lock || !dbg_req || dbg_gnt_raw) begin
      wait_d = '0;
    end else if (wait_q != WaitMax) begin
      wait_d = wait_q + 1'b1;
    end
    cpu_rvalid_d = cpu_gnt_raw & ~cpu_we;
    dbg_rvalid_d = dbg_gnt_raw & ~dbg_we;
    wr_err_d     = prot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      wait_q       <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      wr_err_q     <= wr_err_d;
    end
  end

  // Outputs are gated by reset directly so nothing leaks to memory while it is held.
  always_comb begin
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (rst_n) begin
      cpu_gnt = cpu_gnt_raw;
      dbg_gnt = dbg_gnt_raw;
      if (cpu_gnt_raw) begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we & ~prot;
        mem_wdata = cpu_wdata;
      end else if (dbg_gnt_raw) begin
        mem_addr  = dbg_addr;
        mem_we    = dbg_we;
        mem_wdata = dbg_wdata;
      end
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid_q ? mem_rdata : '0;
  assign cpu_wr_err = wr_err_q;
  assign locked     = (state_q == StLocked);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_wr_err;
  logic [7:0]  cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [15:0] dbg_addr;
  logic [7:0]  dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [7:0]  dbg_rdata;
  logic        locked;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:65535];
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_wr_err (cpu_wr_err),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_lock   (dbg_lock),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .locked     (locked),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'hA9;
    mem[16'h0001] = 8'h05;
    mem[16'h0002] = 8'h77;
    mem[16'hF000] = 8'h3C;
    mem_rdata = 8'h00;
    rst_n = 1'b0;
    {cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock} = '0;
    cpu_addr = 16'h0002; cpu_wdata = 8'h00; dbg_addr = 16'h0000; dbg_wdata = 8'h00;

    // Outputs while reset is asserted, with a CPU read pending.
    tick();
    cpu_req = 1'b1;
    #1;
    check_eq("rst_cpu_gnt", cpu_gnt, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_cpu_rvalid", cpu_rvalid, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_wr_err", cpu_wr_err, 0);

    // Reset mid-read: grant seen, then reset pulsed before the edge completes the read.
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("midrd_gnt", cpu_gnt, 1);
    check_eq("midrd_addr", mem_addr, 16'h0002);
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check_eq("midrd_rst_gnt", cpu_gnt, 0);
    check_eq("midrd_rst_addr", mem_addr, 0);
    tick();
    check_eq("midrd_rvalid0", cpu_rvalid, 0);
    rst_n = 1'b1;
    tick();
    check_eq("midrd_rvalid1", cpu_rvalid, 0);

    // Back-to-back CPU reads.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000;
    tick();
    cpu_addr = 16'h0001;
    check_eq("b2b_rvalid0", cpu_rvalid, 1);
    check_eq("b2b_rdata0", cpu_rdata, 8'hA9);
    tick();
    cpu_req = 1'b0;
    check_eq("b2b_rvalid1", cpu_rvalid, 1);
    check_eq("b2b_rdata1", cpu_rdata, 8'h05);
    tick();
    check_eq("b2b_rvalid2", cpu_rvalid, 0);
    check_eq("b2b_rdata2", cpu_rdata, 0);

    // Starvation bound: debug wins every 5th cycle with MAX_WAIT=4.
    cpu_req = 1'b1; cpu_addr = 16'h0000;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0001;
    for (int k = 1; k <= 10; k++) begin
      #1;
      check_eq($sformatf("starve_dbg_gnt_c%0d", k), dbg_gnt, (k % 5 == 0) ? 1 : 0);
      check_eq($sformatf("starve_cpu_gnt_c%0d", k), cpu_gnt, (k % 5 == 0) ? 0 : 1);
      tick();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();

    // Simultaneous request, then debug drop clears the wait count.
    cpu_req = 1'b1; dbg_req = 1'b1;
    #1;
    check_eq("sim_cpu_gnt", cpu_gnt, 1);
    check_eq("sim_dbg_gnt", dbg_gnt, 0);
    tick();
    check_eq("sim_wait1", 32'(dut.wait_q), 1);
    dbg_req = 1'b0;
    tick();
    check_eq("sim_wait0", 32'(dut.wait_q), 0);
    cpu_req = 1'b0;
    tick();

    // Lock burst: transition cycle still grants the CPU; then debug owns memory.
    dbg_lock = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h0012;
    #1;
    check_eq("lock_trans_cpu_gnt", cpu_gnt, 1);
    check_eq("lock_trans_locked", locked, 0);
    tick();
    check_eq("lock_locked", locked, 1);
    check_eq("lock_pending_rvalid", cpu_rvalid, 1);
    dbg_req = 1'b1; dbg_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dbg_addr = 16'h0010 + 16'(k);
      dbg_wdata = 8'(k + 1);
      #1;
      check_eq($sformatf("lock_dbg_gnt%0d", k), dbg_gnt, 1);
      check_eq($sformatf("lock_cpu_gnt%0d", k), cpu_gnt, 0);
      check_eq($sformatf("lock_mem_we%0d", k), mem_we, 1);
      tick();
    end
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0;
    #1;
    check_eq("unlock_cpu_gnt_still0", cpu_gnt, 0);
    tick();
    check_eq("unlock_locked", locked, 0);
    check_eq("unlock_cpu_gnt", cpu_gnt, 1);
    tick();
    cpu_req = 1'b0;
    check_eq("unlock_rvalid", cpu_rvalid, 1);
    check_eq("unlock_rdata", cpu_rdata, 8'h03);
    tick();

    // Write to the protected region, then read it back through the debug port.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hF000; cpu_wdata = 8'h55;
    #1;
    check_eq("wp_cpu_gnt", cpu_gnt, 1);
`ifdef MEM_ARBITER_WRPROT_EN
    check_eq("wp_mem_we", mem_we, 0);
`else
    check_eq("wp_mem_we", mem_we, 1);
`endif
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'hF000;
`ifdef MEM_ARBITER_WRPROT_EN
    check_eq("wp_wr_err", cpu_wr_err, 1);
`else
    check_eq("wp_wr_err", cpu_wr_err, 0);
`endif
    #1;
    check_eq("wp_dbg_gnt", dbg_gnt, 1);
    tick();
    dbg_req = 1'b0;
    check_eq("wp_wr_err_end", cpu_wr_err, 0);
    check_eq("wp_dbg_rvalid", dbg_rvalid, 1);
`ifdef MEM_ARBITER_WRPROT_EN
    check_eq("wp_dbg_rdata", dbg_rdata, 8'h3C);
`else
    check_eq("wp_dbg_rdata", dbg_rdata, 8'h55);
`endif
    tick();
    check_eq("idle_dbg_rvalid", dbg_rvalid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
